// File: rtl/wb_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter_if
// Purpose : groups the two writeback requester handshakes (port A: in-order
//           writeback, port B: load return) that compete for the single
//           register-file write port.
// Signals : a_valid/a_ready/a_rd/a_data  - port A request, grant and payload
//           b_valid/b_ready/b_rd/b_data  - port B request, grant and payload
// Modports: slave  - the arbiter (takes requests, returns grants)
//           master - the requester side (drives requests, sees grants)
// ---------------------------------------------------------------------------
interface wb_port_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          a_valid;
  logic          a_ready;
  logic [AW-1:0] a_rd;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_rd;
  logic [DW-1:0] b_data;

  modport slave (
    input  a_valid, a_rd, a_data,
    input  b_valid, b_rd, b_data,
    output a_ready, b_ready
  );

  modport master (
    output a_valid, a_rd, a_data,
    output b_valid, b_rd, b_data,
    input  a_ready, b_ready
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
// Purpose : shares the register-file write port between port A (in-order
//           writeback) and port B (long-latency load return). The winning
//           write is registered one cycle after its handshake, and every
//           completed handshake is counted in instret.
// Ports   : clk        - clock, all state on rising edge
//           rst        - asynchronous active-high reset
//           hold       - global stall, no grants while high
//           req        - requester handshakes (wb_port_arbiter_if.slave)
//           rf_wen     - registered register-file write enable
//           rf_waddr   - registered register-file write address
//           rf_wdata   - registered register-file write data
//           instret    - count of completed handshakes (wraps)
//           last_grant - 0 = A granted most recently, 1 = B
// Parameters: DW, AW, CNT_W, FIXED_PRI (0 = round-robin, 1 = A always wins)
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int DW        = 32,
  parameter int AW        = 5,
  parameter int CNT_W     = 64,
  parameter int FIXED_PRI = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  wb_port_arbiter_if.slave     req,
  output logic                 rf_wen,
  output logic [AW-1:0]        rf_waddr,
  output logic [DW-1:0]        rf_wdata,
  output logic [CNT_W-1:0]     instret,
  output logic                 last_grant
);

  // Round-robin pointer: which port wins when both request together.
  typedef enum logic {
    PREF_A = 1'b0,
    PREF_B = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              grant_a, grant_b;
  logic              handshake;
  logic [AW-1:0]     win_rd;
  logic [DW-1:0]     win_data;

  logic              rf_wen_q, rf_wen_d;
  logic [AW-1:0]     rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]     rf_wdata_q, rf_wdata_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic              last_grant_q, last_grant_d;

  // Grant selection and pointer update. Grants are purely combinational from
  // valid, hold and the pointer, so a requester sees ready in the same cycle.
  always_comb begin
    state_d = state_q;
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!hold) begin
      if (FIXED_PRI != 0) begin
        if (req.a_valid) begin
          grant_a = 1'b1;
        end else if (req.b_valid) begin
          grant_b = 1'b1;
        end
        // Pointer only mirrors the last winner here; it never steers grants.
        if (grant_a) begin
          state_d = PREF_B;
        end else if (grant_b) begin
          state_d = PREF_A;
        end
      end else begin
        unique case (state_q)
          PREF_A: begin
            if (req.a_valid) begin
              grant_a = 1'b1;
              // Hand preference over only if B was actually waiting.
              state_d = req.b_valid ? PREF_B : PREF_A;
            end else if (req.b_valid) begin
              grant_b = 1'b1;
            end
          end
          PREF_B: begin
            if (req.b_valid) begin
              grant_b = 1'b1;
              state_d = req.a_valid ? PREF_A : PREF_B;
            end else if (req.a_valid) begin
              grant_a = 1'b1;
            end
          end
          default: begin
            state_d = PREF_A;
          end
        endcase
      end
    end
  end

  assign req.a_ready = grant_a;
  assign req.b_ready = grant_b;

  assign handshake = grant_a | grant_b;
  assign win_rd    = grant_b ? req.b_rd   : req.a_rd;
  assign win_data  = grant_b ? req.b_data : req.a_data;

  // Write-port registers and retire counter next state.
  always_comb begin
    rf_wen_d     = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    instret_d    = instret_q;
    last_grant_d = last_grant_q;
    if (handshake) begin
      // x0 is architecturally zero: the handshake retires but nothing is
      // written, and the address/data registers keep the last real write.
      if (win_rd != '0) begin
        rf_wen_d   = 1'b1;
        rf_waddr_d = win_rd;
        rf_wdata_d = win_data;
      end
      instret_d    = instret_q + CNT_W'(1);
      last_grant_d = grant_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= PREF_A;
      rf_wen_q     <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      instret_q    <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      rf_wen_q     <= rf_wen_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      instret_q    <= instret_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rf_wen     = rf_wen_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign instret    = instret_q;
  assign last_grant = last_grant_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
// Bench for wb_port_arbiter. Two instances share the stimulus: u_rr is a
// round-robin build with a 64-bit counter, u_fx a fixed-priority build with a
// 4-bit counter. sel chooses which instance is being observed. The reference
// model tracks a contention pointer that flips only when both ports request
// and one is granted, plus the expected write-port and counter contents.
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold_r = 1'b0;
  logic        av = 1'b0, bv = 1'b0;
  logic [4:0]  ard = '0, brd = '0;
  logic [31:0] adata = '0, bdata = '0;
  logic        sel = 1'b0;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic        m_pref;
  logic        m_last;
  logic        m_wen;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [63:0] m_cnt;

  logic        obs_a, obs_b;

  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DW(32), .AW(5)) if_r ();
  wb_port_arbiter_if #(.DW(32), .AW(5)) if_f ();

  assign if_r.a_valid = av;
  assign if_r.a_rd    = ard;
  assign if_r.a_data  = adata;
  assign if_r.b_valid = bv;
  assign if_r.b_rd    = brd;
  assign if_r.b_data  = bdata;
  assign if_f.a_valid = av;
  assign if_f.a_rd    = ard;
  assign if_f.a_data  = adata;
  assign if_f.b_valid = bv;
  assign if_f.b_rd    = brd;
  assign if_f.b_data  = bdata;

  logic        wen_r, wen_f, lg_r, lg_f;
  logic [4:0]  waddr_r, waddr_f;
  logic [31:0] wdata_r, wdata_f;
  logic [63:0] ins_r;
  logic [3:0]  ins_f;

  wb_port_arbiter #(.DW(32), .AW(5), .CNT_W(64), .FIXED_PRI(0)) u_rr (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold_r),
    .req        (if_r),
    .rf_wen     (wen_r),
    .rf_waddr   (waddr_r),
    .rf_wdata   (wdata_r),
    .instret    (ins_r),
    .last_grant (lg_r)
  );

  wb_port_arbiter #(.DW(32), .AW(5), .CNT_W(4), .FIXED_PRI(1)) u_fx (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold_r),
    .req        (if_f),
    .rf_wen     (wen_f),
    .rf_waddr   (waddr_f),
    .rf_wdata   (wdata_f),
    .instret    (ins_f),
    .last_grant (lg_f)
  );

  // observed instance
  logic        o_ar, o_br, o_wen, o_lg;
  logic [4:0]  o_waddr;
  logic [31:0] o_wdata;
  logic [63:0] o_ins;
  assign o_ar    = sel ? if_f.a_ready : if_r.a_ready;
  assign o_br    = sel ? if_f.b_ready : if_r.b_ready;
  assign o_wen   = sel ? wen_f : wen_r;
  assign o_lg    = sel ? lg_f : lg_r;
  assign o_waddr = sel ? waddr_f : waddr_r;
  assign o_wdata = sel ? wdata_f : wdata_r;
  assign o_ins   = sel ? {60'd0, ins_f} : ins_r;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pref = 1'b0;
    m_last = 1'b1;
    m_wen  = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_cnt  = '0;
  endtask

  // Who should win this cycle: nobody under hold; a lone requester always
  // wins; with both requesting, A in the fixed build, else the pointer.
  task automatic model_grant(output logic ea, output logic eb);
    ea = 1'b0;
    eb = 1'b0;
    if (!hold_r) begin
      if (sel || !(av && bv)) begin
        if (av)      ea = 1'b1;
        else if (bv) eb = 1'b1;
      end else begin
        ea = (m_pref == 1'b0);
        eb = (m_pref == 1'b1);
      end
    end
  endtask

  task automatic step();
    logic ea, eb;
    logic [63:0] exp_cnt;
    @(negedge clk);
    model_grant(ea, eb);
    obs_a = o_ar;
    obs_b = o_br;
    chk("a_ready", 64'(o_ar), 64'(ea));
    chk("b_ready", 64'(o_br), 64'(eb));
    @(posedge clk);
    #1;
    if (ea || eb) begin
      m_cnt = m_cnt + 64'd1;
      m_wen = ea ? (ard != 5'd0) : (brd != 5'd0);
      if (m_wen) begin
        m_addr = ea ? ard : brd;
        m_data = ea ? adata : bdata;
      end
      if (!sel && av && bv) m_pref = ~m_pref;
      m_last = eb;
    end else begin
      m_wen = 1'b0;
    end
    exp_cnt = sel ? (m_cnt & 64'hF) : m_cnt;
    chk("rf_wen", 64'(o_wen), 64'(m_wen));
    chk("instret", o_ins, exp_cnt);
    chk("last_grant", 64'(o_lg), 64'(m_last));
    if (m_wen) begin
      chk("rf_waddr", 64'(o_waddr), 64'(m_addr));
      chk("rf_wdata", 64'(o_wdata), 64'(m_data));
    end
  endtask

  // Requesters: a port that is idle or was just granted may post a new
  // request; a waiting port keeps its request untouched.
  task automatic next_reqs(input int pct);
    if (!av || obs_a) begin
      av    = ($urandom_range(0, 99) < pct);
      ard   = 5'($urandom_range(0, 31));
      adata = $urandom;
    end
    if (!bv || obs_b) begin
      bv    = ($urandom_range(0, 99) < pct);
      brd   = 5'($urandom_range(0, 31));
      bdata = $urandom;
    end
    hold_r = ($urandom_range(0, 9) < 2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    av = 1'b0;
    bv = 1'b0;
    hold_r = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    obs_a = 1'b0;
    obs_b = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    model_reset();
    obs_a = 1'b0;
    obs_b = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // reset values
    chk("rst_wen", 64'(o_wen), 64'd0);
    chk("rst_waddr", 64'(o_waddr), 64'd0);
    chk("rst_wdata", 64'(o_wdata), 64'd0);
    chk("rst_instret", o_ins, 64'd0);
    chk("rst_last_grant", 64'(o_lg), 64'd1);

    // single A write
    av = 1'b1; ard = 5'd5; adata = 32'hDEADBEEF;
    step();
    chk("single_a_ready", 64'(obs_a), 64'd1);
    chk("single_wen", 64'(o_wen), 64'd1);
    chk("single_waddr", 64'(o_waddr), 64'd5);
    chk("single_wdata", 64'(o_wdata), 64'hDEADBEEF);
    chk("single_instret", o_ins, 64'd1);
    av = 1'b0;

    // write to x0 from B
    bv = 1'b1; brd = 5'd0; bdata = 32'h1234;
    step();
    chk("x0_b_ready", 64'(obs_b), 64'd1);
    chk("x0_wen", 64'(o_wen), 64'd0);
    chk("x0_instret", o_ins, 64'd2);
    bv = 1'b0;

    // hold with both waiting, then release
    av = 1'b1; ard = 5'd7; adata = 32'hA5A5_0007;
    bv = 1'b1; brd = 5'd9; bdata = 32'h5A5A_0009;
    hold_r = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_no_ready", 64'(obs_a | obs_b), 64'd0);
      chk("hold_no_wen", 64'(o_wen), 64'd0);
    end
    hold_r = 1'b0;
    step();
    chk("hold_rel_a", 64'(obs_a), 64'd1);
    av = 1'b0;
    step();
    chk("hold_rel_b", 64'(obs_b), 64'd1);
    chk("hold_rel_waddr", 64'(o_waddr), 64'd9);
    chk("hold_instret", o_ins, 64'd4);
    bv = 1'b0;

    // randomized round-robin traffic
    for (int i = 0; i < 400; i++) begin
      next_reqs(70);
      step();
    end
    hold_r = 1'b0;

    // asynchronous reset mid-run with A requesting
    av = 1'b1; ard = 5'd3; adata = 32'h0BAD_F00D;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_wen", 64'(o_wen), 64'd0);
    chk("arst_waddr", 64'(o_waddr), 64'd0);
    chk("arst_wdata", 64'(o_wdata), 64'd0);
    chk("arst_instret", o_ins, 64'd0);
    chk("arst_last_grant", 64'(o_lg), 64'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();

    // contention: strict alternation starting with A
    av = 1'b1; bv = 1'b1; brd = 5'd11; bdata = 32'hB000_0000;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_alt_a", 64'(obs_a), 64'((i % 2) == 0));
      chk("rr_alt_b", 64'(obs_b), 64'((i % 2) == 1));
      if (obs_a) adata = adata + 32'd1;
      if (obs_b) bdata = bdata + 32'd1;
    end
    chk("rr_cont_instret", o_ins, 64'd6);

    // fixed-priority build
    sel = 1'b1;
    do_reset();
    av = 1'b1; ard = 5'd4; adata = 32'h1000;
    bv = 1'b1; brd = 5'd6; bdata = 32'h2000;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("fx_a", 64'(obs_a), 64'd1);
      chk("fx_b", 64'(obs_b), 64'd0);
      adata = adata + 32'd1;
    end
    chk("fx_cont_instret", o_ins, 64'd6);

    // 4-bit counter wraps after 16 handshakes
    do_reset();
    av = 1'b1;
    for (int i = 0; i < 17; i++) begin
      ard   = 5'($urandom_range(1, 31));
      adata = $urandom;
      step();
    end
    chk("wrap_instret", o_ins, 64'd1);
    av = 1'b0;

    for (int i = 0; i < 200; i++) begin
      next_reqs(70);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
